// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor. It computes diff = a - b (mod 2^WIDTH)
//   one bit per clock, starting at the LSB, and reports the final borrow-out.
//
// Ports
//   clk     in   clock; all state changes on its rising edge
//   rst_n   in   asynchronous reset, active low
//   start   in   request a subtraction; looked at only in IDLE
//   a       in   minuend, captured when start is accepted
//   b       in   subtrahend, captured when start is accepted
//   busy    out  high while bits are being processed (RUN)
//   done    out  one-cycle pulse; diff/borrow are valid from here on
//   diff    out  a - b modulo 2^WIDTH
//   borrow  out  final borrow-out; high when a < b unsigned
//   ovf     out  two's-complement overflow; present only with SERIAL_SUB_OVF_EN
//
// Build option
//   SERIAL_SUB_OVF_EN  when defined, adds the ovf output and its logic.
//
// Timing
//   edge 1 accepts start, edges 2..WIDTH+1 process bits 0..WIDTH-1,
//   and done is high in the cycle after edge WIDTH+1.
//
// state | meaning
// IDLE  | waiting for start; diff/borrow hold the last result
// RUN   | one bit of the difference is produced per cycle, LSB first
// DONE  | result complete; done is high for this one cycle

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             borrow_q;
  logic             busy_q;
  logic             done_q;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q;
`endif

  // One full-subtractor cell, fed by the operand bits selected by the counter.
  logic a_bit;
  logic b_bit;
  logic d_bit_d;
  logic br_d;

  always_comb begin
    a_bit   = a_q[cnt_q];
    b_bit   = b_q[cnt_q];
    d_bit_d = a_bit ^ b_bit ^ br_q;
    br_d    = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          // Upper diff bits keep their previous value until their turn.
          diff_q[cnt_q] <= d_bit_d;
          br_q          <= br_d;
          if (cnt_q == LAST_BIT) begin
            borrow_q <= br_d;
`ifdef SERIAL_SUB_OVF_EN
            // Overflow only when operand signs differ and the result sign
            // disagrees with the minuend; d_bit_d is the result MSB here.
            ovf_q    <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (d_bit_d ^ a_q[WIDTH-1]);
`endif
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=8): a vector table plus hand-written
// corner sequences; expected results go on a queue when start is driven and
// are popped and compared whenever the DUT pulses done.

module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         br;
    logic         ov;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb);
    exp_t      e;
    logic [W:0] full;
    full = {1'b0, ma} - {1'b0, mb};
    e.d  = full[W-1:0];
    e.br = full[W];
    e.ov = (ma[W-1] != mb[W-1]) && (e.d[W-1] != ma[W-1]);
    return e;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_diff", 32'(diff), 32'(e.d));
        chk("sb_borrow", 32'(borrow), 32'(e.br));
`ifdef SERIAL_SUB_OVF_EN
        chk("sb_ovf", 32'(ovf), 32'(e.ov));
`endif
      end
    end
  end

  // Caller must be at a negedge. chg: change a/b in RUN cycle 3.
  // rs: re-pulse start with new operands in RUN cycle 3.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] ed, input logic eb,
                        input bit chg, input bit rs);
    int lat;
    int busy_cnt;
    a     = va;
    b     = vb;
    start = 1'b1;
    sb_q.push_back('{d: ed, br: eb, ov: model(va, vb).ov});
    @(negedge clk);
    start    = 1'b0;
    lat      = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
      if (lat == 3 && (chg || rs)) begin
        a = ~va;
        b = va ^ 8'h3C;
        if (rs) start = 1'b1;
      end
      if (lat == 4) start = 1'b0;
    end
    chk("latency", 32'(lat), 32'(W + 1));
    chk("busy_cycles", 32'(busy_cnt), 32'(W));
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("hold_diff", 32'(diff), 32'(ed));
    chk("hold_borrow", 32'(borrow), 32'(eb));
  endtask

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] ed;
    logic         eb;
    bit           chg;
    bit           rs;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'hA5, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{8'h5A, 8'h1F, 8'h3B, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    // Start is presented together with reset release: first edge accepts it.
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].va, vecs[i].vb, vecs[i].ed, vecs[i].eb, vecs[i].chg, vecs[i].rs);

`ifdef SERIAL_SUB_OVF_EN
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0);
    chk("ovf_80_01", 32'(ovf), 32'd1);
    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
    chk("ovf_05_03", 32'(ovf), 32'd0);
`endif

    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      exp_t         e;
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      e  = model(ra, rb);
      run_op(ra, rb, e.d, e.br, 1'b0, 1'b0);
    end

    // Reset in RUN cycle 4: outputs clear at once and no done follows.
    a     = 8'h00;
    b     = 8'h01;
    start = 1'b1;
    sb_q.push_back(model(8'h00, 8'h01));
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_diff", 32'(diff), 32'd0);
    chk("midrst_borrow", 32'(borrow), 32'd0);
    repeat (12) @(negedge clk);
    chk("midrst_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);

    repeat (12) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
